demux_1x2_sched: RTL and testbench

- Sequencing controller for the 1:2 demultiplexer path: takes one valid/ready input stream and steers each beat to output channel 0 or 1.
- Two steering modes: burst round-robin (BURST beats per channel, then switch) or tag-directed (per-beat destination bit).
- Each output has a one-entry register slot. The block sits between a single producer and two independent consumers.

---
 rtl/demux_sched_pkg.sv | 19 +
 rtl/demux_out_slot.sv | 33 +++
 rtl/demux_1x2_sched.sv | 127 ++++++++++++
 tb/tb_demux_1x2_sched.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the 1:2 demux scheduler.
// The optional DEMUX_SCHED_STATS_EN build uses STATS_W for its per-channel drain counters.
package demux_sched_pkg;

    typedef enum logic {
        S_CH0 = 1'b0,
        S_CH1 = 1'b1
    } state_t;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_TAG = 1'b1;

    localparam int STATS_W = 16;

    function automatic state_t sel_to_state(input logic sel);
        return sel ? S_CH1 : S_CH0;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready register slice feeding one demux output channel.
// A load while the slot drains replaces the old beat, giving one beat per cycle.
module demux_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             Valid,
    input  logic             Ready,
    output logic [WIDTH-1:0] Data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= data_in;
        end else if (valid_q && Ready) begin
            valid_q <= 1'b0;
        end
    end

    assign Valid = valid_q;
    assign Data  = data_q;

endmodule

// File: rtl/demux_1x2_sched.sv
// 1:2 demux sequencer: burst round-robin or tag-directed steering into two output slots.
// Define DEMUX_SCHED_STATS_EN to add saturating per-channel drain counters Cnt0/Cnt1.
module demux_1x2_sched
    import demux_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Mode,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             In_Dest,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Y0_Data,
    output logic             Y0_Valid,
    input  logic             Y0_Ready,
    output logic [WIDTH-1:0] Y1_Data,
    output logic             Y1_Valid,
    input  logic             Y1_Ready,
    output logic             Cur_Sel,
    output logic             Busy
`ifdef DEMUX_SCHED_STATS_EN
    ,
    output logic [STATS_W-1:0] Cnt0,
    output logic [STATS_W-1:0] Cnt1
`endif
);

    localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             mode_eff;
    logic             tgt;
    logic             accept;
    logic [1:0]       slot_full;
    logic [1:0]       slot_ready;
    logic [1:0]       slot_load;
    logic [WIDTH-1:0] slot_data [2];

    // At a burst boundary the live Mode input governs, so a pending mode change
    // applies to the very next beat; mid-burst the latched mode holds.
    assign mode_eff   = (cnt_q == '0) ? Mode : mode_q;
    assign tgt        = (mode_eff == MODE_TAG) ? In_Dest : (state_q == S_CH1);
    assign slot_ready = {Y1_Ready, Y0_Ready};
    assign In_Ready   = ~Rst & (~slot_full[tgt] | slot_ready[tgt]);
    assign accept     = In_Valid & In_Ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_load[gi] = accept & (tgt == 1'(gi));

            demux_out_slot #(.WIDTH(WIDTH)) u_slot (
                .Clk     (Clk),
                .Rst     (Rst),
                .load    (slot_load[gi]),
                .data_in (In_Data),
                .Valid   (slot_full[gi]),
                .Ready   (slot_ready[gi]),
                .Data    (slot_data[gi])
            );
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_CH0;
            cnt_q   <= '0;
            mode_q  <= MODE_RR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        if (cnt_q == '0) begin
            mode_d = Mode;
        end
        if (accept) begin
            if (mode_eff == MODE_TAG) begin
                state_d = sel_to_state(In_Dest);
                cnt_d   = '0;
            end else if (cnt_q == BURST_LAST) begin
                cnt_d   = '0;
                state_d = (state_q == S_CH0) ? S_CH1 : S_CH0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    assign Y0_Data  = slot_data[0];
    assign Y1_Data  = slot_data[1];
    assign Y0_Valid = slot_full[0];
    assign Y1_Valid = slot_full[1];
    assign Cur_Sel  = (state_q == S_CH1);
    assign Busy     = (|slot_full) | (cnt_q != '0);

`ifdef DEMUX_SCHED_STATS_EN
    logic [STATS_W-1:0] stat_q [2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    stat_q[gi] <= '0;
                end else if (slot_full[gi] && slot_ready[gi] && (stat_q[gi] != '1)) begin
                    stat_q[gi] <= stat_q[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign Cnt0 = stat_q[0];
    assign Cnt1 = stat_q[1];
`endif

endmodule

// File: tb/tb_demux_1x2_sched.sv
// Self-checking bench for demux_1x2_sched: per-channel scoreboards fed on accept, popped on drain.
// Build with DEMUX_SCHED_STATS_EN defined to also exercise the drain counters.
module tb_demux_1x2_sched;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Mode = 1'b0;
    logic [7:0] In_Data = '0;
    logic       In_Dest = 1'b0;
    logic       In_Valid = 1'b0;
    logic       In_Ready;
    logic [7:0] Y0_Data, Y1_Data;
    logic       Y0_Valid, Y1_Valid;
    logic       Y0_Ready = 1'b1;
    logic       Y1_Ready = 1'b1;
    logic       Cur_Sel, Busy;
`ifdef DEMUX_SCHED_STATS_EN
    logic [15:0] Cnt0, Cnt1;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    demux_1x2_sched #(.WIDTH(8), .BURST(4)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Mode     (Mode),
        .In_Data  (In_Data),
        .In_Dest  (In_Dest),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .Y0_Data  (Y0_Data),
        .Y0_Valid (Y0_Valid),
        .Y0_Ready (Y0_Ready),
        .Y1_Data  (Y1_Data),
        .Y1_Valid (Y1_Valid),
        .Y1_Ready (Y1_Ready),
        .Cur_Sel  (Cur_Sel),
        .Busy     (Busy)
`ifdef DEMUX_SCHED_STATS_EN
        ,
        .Cnt0     (Cnt0),
        .Cnt1     (Cnt1)
`endif
    );

    always #5 Clk = ~Clk;

    // Drain-side scoreboard: sampled mid-low-phase, the transfer happens at the next rising edge.
    always @(negedge Clk) begin
        #3;
        if (!Rst && Y0_Valid && Y0_Ready) begin
            checks++;
            if (exp_q0.size() == 0) begin
                errors++;
                $display("FAIL y0_unexpected got=%h required=none", Y0_Data);
            end else begin
                logic [7:0] e0;
                e0 = exp_q0.pop_front();
                if (Y0_Data !== e0) begin
                    errors++;
                    $display("FAIL y0_data got=%h required=%h", Y0_Data, e0);
                end
            end
        end
        if (!Rst && Y1_Valid && Y1_Ready) begin
            checks++;
            if (exp_q1.size() == 0) begin
                errors++;
                $display("FAIL y1_unexpected got=%h required=none", Y1_Data);
            end else begin
                logic [7:0] e1;
                e1 = exp_q1.pop_front();
                if (Y1_Data !== e1) begin
                    errors++;
                    $display("FAIL y1_data got=%h required=%h", Y1_Data, e1);
                end
            end
        end
    end

    task automatic do_reset();
        Rst = 1'b1;
        In_Valid = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic idle(input int n);
        In_Valid = 1'b0;
        repeat (n) @(negedge Clk);
    endtask

    // Presents one beat, waits (bounded) for acceptance, books it for channel ch,
    // and checks it sits in that channel's slot one cycle later.
    task automatic send(input logic [7:0] d, input logic dest, input logic ch);
        int n;
        logic ov;
        logic [7:0] od;
        n = 0;
        In_Data = d;
        In_Dest = dest;
        In_Valid = 1'b1;
        #1;
        while (!In_Ready && n < 50) begin
            @(negedge Clk);
            #1;
            n++;
        end
        if (!In_Ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout data=%h in_ready=%b required=1", d, In_Ready);
            In_Valid = 1'b0;
            return;
        end
        if (ch) exp_q1.push_back(d);
        else    exp_q0.push_back(d);
        @(posedge Clk);
        @(negedge Clk);
        ov = ch ? Y1_Valid : Y0_Valid;
        od = ch ? Y1_Data  : Y0_Data;
        checks++;
        if (ov !== 1'b1 || od !== d) begin
            errors++;
            $display("FAIL latency_ch%0d got valid=%b data=%h required valid=1 data=%h", ch, ov, od, d);
        end
        $display("beat %h dest=%b -> ch%0d cur_sel=%b", d, dest, ch, Cur_Sel);
        In_Valid = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        In_Valid = 1'b1;
        In_Data = 8'hEE;
        Y0_Ready = 1'b1;
        Y1_Ready = 1'b1;
        repeat (2) @(negedge Clk);
        #1;
        checks++;
        if ({In_Ready, Y0_Valid, Y1_Valid, Cur_Sel, Busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b v0=%b v1=%b sel=%b busy=%b required all 0",
                     In_Ready, Y0_Valid, Y1_Valid, Cur_Sel, Busy);
        end
        checks++;
        if (Y0_Data !== 8'h00 || Y1_Data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got y0=%h y1=%h required 00 00", Y0_Data, Y1_Data);
        end
        Rst = 1'b0;
        In_Valid = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_round_robin();
        logic exp_sel;
        do_reset();
        Mode = 1'b0;
        Y0_Ready = 1'b1;
        Y1_Ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(8'h10 + 8'(i), 1'b0, (i >= 4));
            exp_sel = ((i + 1) / 4) % 2 == 1;
            checks++;
            if (Cur_Sel !== exp_sel) begin
                errors++;
                $display("FAIL rr_cur_sel beat=%0d got=%b required=%b", i, Cur_Sel, exp_sel);
            end
        end
        idle(2);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_busy_idle got=%b required=0", Busy);
        end
`ifdef DEMUX_SCHED_STATS_EN
        checks++;
        if (Cnt0 !== 16'd4 || Cnt1 !== 16'd4) begin
            errors++;
            $display("FAIL stats_counts got cnt0=%0d cnt1=%0d required 4 4", Cnt0, Cnt1);
        end
`endif
    endtask

    task automatic test_backpressure();
        do_reset();
        Mode = 1'b0;
        Y0_Ready = 1'b0;
        Y1_Ready = 1'b1;
        send(8'h10, 1'b0, 1'b0);
        In_Data = 8'h11;
        In_Valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (In_Ready !== 1'b0 || Y0_Valid !== 1'b1 || Y0_Data !== 8'h10) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got rdy=%b v0=%b d0=%h required rdy=0 v0=1 d0=10",
                         i, In_Ready, Y0_Valid, Y0_Data);
            end
            @(negedge Clk);
        end
        Y0_Ready = 1'b1;
        send(8'h11, 1'b0, 1'b0);
        send(8'h12, 1'b0, 1'b0);
        send(8'h13, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (exp_q0.size() != 0 || Cur_Sel !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain got pending=%0d sel=%b required pending=0 sel=1", exp_q0.size(), Cur_Sel);
        end
    endtask

    task automatic test_tag();
        do_reset();
        Mode = 1'b1;
        Y0_Ready = 1'b1;
        Y1_Ready = 1'b1;
        send(8'hA0, 1'b1, 1'b1);
        send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b1, 1'b1);
        checks++;
        if (Cur_Sel !== 1'b1) begin
            errors++;
            $display("FAIL tag_cur_sel got=%b required=1", Cur_Sel);
        end
        idle(1);
        Y1_Ready = 1'b0;
        send(8'hB0, 1'b1, 1'b1);
        In_Data = 8'hB1;
        In_Dest = 1'b1;
        In_Valid = 1'b1;
        #1;
        checks++;
        if (In_Ready !== 1'b0) begin
            errors++;
            $display("FAIL tag_stall_ready got=%b required=0", In_Ready);
        end
        send(8'hB2, 1'b0, 1'b0);
        checks++;
        if (Y1_Valid !== 1'b1 || Y1_Data !== 8'hB0) begin
            errors++;
            $display("FAIL tag_y1_hold got v1=%b d1=%h required v1=1 d1=b0", Y1_Valid, Y1_Data);
        end
        Y1_Ready = 1'b1;
        send(8'hB1, 1'b1, 1'b1);
        idle(2);
    endtask

    task automatic test_deferred_mode();
        do_reset();
        Mode = 1'b0;
        Y0_Ready = 1'b1;
        Y1_Ready = 1'b1;
        send(8'h20, 1'b0, 1'b0);
        send(8'h21, 1'b0, 1'b0);
        Mode = 1'b1;
        send(8'h22, 1'b1, 1'b0);
        send(8'h23, 1'b1, 1'b0);
        checks++;
        if (Cur_Sel !== 1'b1) begin
            errors++;
            $display("FAIL defer_burst_end_sel got=%b required=1", Cur_Sel);
        end
        send(8'h24, 1'b0, 1'b0);
        send(8'h25, 1'b0, 1'b0);
        Mode = 1'b0;
        send(8'h26, 1'b1, 1'b0);
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL defer_busy_mid_burst got=%b required=1", Busy);
        end
        send(8'h27, 1'b1, 1'b0);
        send(8'h28, 1'b1, 1'b0);
        send(8'h29, 1'b1, 1'b0);
        send(8'h2A, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic test_mid_reset();
        do_reset();
        Mode = 1'b0;
        Y0_Ready = 1'b1;
        Y1_Ready = 1'b1;
        send(8'h30, 1'b0, 1'b0);
        send(8'h31, 1'b0, 1'b0);
        send(8'h32, 1'b0, 1'b0);
        Y0_Ready = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        @(negedge Clk);
        #1;
        checks++;
        if (Y0_Valid !== 1'b0 || Busy !== 1'b0 || Cur_Sel !== 1'b0 || In_Ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset got v0=%b busy=%b sel=%b rdy=%b required all 0",
                     Y0_Valid, Busy, Cur_Sel, In_Ready);
        end
        Rst = 1'b0;
        Y0_Ready = 1'b1;
        send(8'h55, 1'b0, 1'b0);
        send(8'h56, 1'b0, 1'b0);
        send(8'h57, 1'b0, 1'b0);
        send(8'h58, 1'b0, 1'b0);
        send(8'h59, 1'b0, 1'b1);
        idle(2);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_tag();
        test_deferred_mode();
        test_mid_reset();
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got q0=%0d q1=%0d required 0 0", exp_q0.size(), exp_q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
